dm9000_bus_arbiter: RTL and testbench
=====================================

DM9000_BUS_ARBITER -- requirements
Module: dm9000_bus_arbiter

Interface
REQ-001 SHALL have parameter T_SU, default 1, meaning setup cycles before each strobe (legal 1..15).
REQ-002 SHALL have parameter T_PW, default 2, meaning strobe low cycles (legal 1..15).
REQ-003 SHALL have parameter T_HD, default 1, meaning hold cycles after each strobe (legal 1..15).
REQ-004 SHALL have port clk50M  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst_key  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports req0/req1  in  1  access request from requester 0/1.
REQ-007 SHALL have ports we0/we1  in  1  1=register write, 0=register read.
REQ-008 SHALL have ports addr0/addr1  in  8  DM9000 register index.
REQ-009 SHALL have ports wdata0/wdata1  in  16  write data.
REQ-010 SHALL have ports gnt0/gnt1  out  1  requester owns bus.
REQ-011 SHALL have ports done0/done1  out  1  one-cycle completion pulse.
REQ-012 SHALL have port rdata  out  16  last read result.
REQ-013 SHALL have port busy  out  1  transaction in progress.
REQ-014 SHALL have ports eth_data  inout  16; eth_cs, eth_cmd, eth_ior, eth_iow  out  1  each, all active-low except eth_cmd (0=index, 1=data).

Function
REQ-015 SHALL use states IDLE, IDX_SU, IDX_PW, IDX_HD, DAT_SU, DAT_PW, DAT_HD, DONE; one shared 4-bit phase counter.
REQ-016 SHALL, in IDLE with any req high at an edge, grant per arbitration, latch that requester's we/addr/wdata, go to IDX_SU, assert gnt from that edge.
REQ-017 SHALL hold each of *_SU, *_PW, *_HD for exactly T_SU, T_PW, T_HD cycles respectively.
REQ-018 SHALL drive eth_cs=0 in all states IDX_SU..DAT_HD, else 1.
REQ-019 SHALL drive eth_cmd=0 in IDX_* states, else 1.
REQ-020 SHALL drive eth_iow=0 in IDX_PW, and in DAT_PW when latched we=1; else 1.
REQ-021 SHALL drive eth_ior=0 in DAT_PW when latched we=0; else 1.
REQ-022 SHALL drive eth_data={8'h00,addr} in IDX_*, wdata in DAT_* when we=1, hi-Z otherwise (all read phases, IDLE, DONE).
REQ-023 SHALL capture eth_data into rdata at the edge ending the last DAT_PW cycle of a read; rdata unchanged on writes.
REQ-024 SHALL in DONE pulse done of granted requester for one cycle, drop its gnt at end of DONE, return to IDLE.
REQ-025 SHALL force at least one IDLE cycle between transactions (bus turnaround); defaults give grant-to-done = 8 cycles, req-to-req period = 10 cycles.
REQ-026 SHALL complete a granted transaction even if req drops mid-transaction; latched fields immune to input changes.
REQ-027 SHALL ignore the non-granted req until IDLE; it is served at next arbitration if still high.
REQ-028 SHALL drive busy=1 in every state except IDLE.
REQ-029 SHALL, without ETH_ARB_RR_EN, give fixed priority req0 > req1 when both high in IDLE.

Reset
REQ-030 SHALL on rst_key=0 immediately (asynchronously) enter IDLE: gnt0/1=0, done0/1=0, busy=0, rdata=16'h0000, eth_cs=eth_ior=eth_iow=eth_cmd=1, eth_data hi-Z.
REQ-031 SHALL abort any in-flight transaction on reset with no done pulse; first arbitration occurs on first edge after rst_key rises with req high.

Configuration
REQ-032 SHALL, with ETH_ARB_RR_EN defined, arbitrate round-robin: on simultaneous requests the requester not granted last wins; last-grant pointer resets to 1 (so requester 0 wins first tie).
REQ-033 SHALL, with ETH_ARB_RR_EN undefined, use fixed priority of REQ-029 and contain no pointer register.

Verification
REQ-034 SHALL cover write: req0, we0=1, addr0=8'h28, wdata0=16'h1234 -> eth_data 16'h0028 with eth_cmd=0 and iow=0 for 2 cycles, then 16'h1234 with eth_cmd=1 and iow=0 for 2 cycles, done0 8 cycles after gnt0.
REQ-035 SHALL cover read: req1, we1=0, addr1=8'h29, model returns 16'h0A46 while ior=0 -> rdata=16'h0A46 when done1 pulses; eth_data hi-Z throughout data phase.
REQ-036 SHALL cover tie: req0 and req1 held high continuously -> fixed: gnt0 every transaction, req1 starved; ETH_ARB_RR_EN: grants alternate 0,1,0,1 with one IDLE cycle between.
REQ-037 SHALL cover reset mid-operation: rst_key=0 during IDX_PW -> same cycle eth_iow=1, eth_cs=1, bus hi-Z, gnt0=0, no done0.
REQ-038 SHALL cover req drop: req0 deasserted and addr0 changed after grant -> transaction completes with original addr, done0 pulses once.
REQ-039 SHALL cover parameters T_SU=2, T_PW=3, T_HD=1 -> strobe low exactly 3 cycles, grant-to-done 12 cycles.

Source files
------------

// File: rtl/dm9000_bus_arbiter.sv
// DM9000 register-bus arbiter: two requesters, index+data cycle sequencer.
// Ports: clk50M/rst_key, req/we/addr/wdata/gnt/done per requester, rdata, busy, eth_* bus. Option: ETH_ARB_RR_EN.
`timescale 1ns/1ps
module dm9000_bus_arbiter #(
  parameter int unsigned T_SU = 1,
  parameter int unsigned T_PW = 2,
  parameter int unsigned T_HD = 1
) (
  input  logic        clk50M,
  input  logic        rst_key,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [7:0]  addr0,
  input  logic [7:0]  addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] rdata,
  output logic        busy,
  inout  wire  [15:0] eth_data,
  output logic        eth_cs,
  output logic        eth_cmd,
  output logic        eth_ior,
  output logic        eth_iow
);

  typedef enum logic [2:0] {
    IDLE, IDX_SU, IDX_PW, IDX_HD,
    DAT_SU, DAT_PW, DAT_HD, DONE
  } state_t;

  localparam logic [3:0] SU_L = 4'(T_SU - 1);
  localparam logic [3:0] PW_L = 4'(T_PW - 1);
  localparam logic [3:0] HD_L = 4'(T_HD - 1);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        own;
  logic        we_q;
  logic [7:0]  addr_q;
  logic [15:0] wdata_q;
  logic        pick;
  logic        any_req;
  logic        idx, dat, drive;
  logic [15:0] dout;

  assign any_req = req0 | req1;

`ifdef ETH_ARB_RR_EN
  logic last;
  // on a tie, the requester not served last wins
  assign pick = (req0 & req1) ? ~last : req1;

  always_ff @(posedge clk50M or negedge rst_key) begin
    if (!rst_key)
      last <= 1'b1;
    else if (state == IDLE && any_req)
      last <= pick;
  end
`else
  assign pick = ~req0;
`endif

  always_ff @(posedge clk50M or negedge rst_key) begin
    if (!rst_key) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk50M or negedge rst_key) begin
    if (!rst_key) begin
      own     <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        own     <= pick;
        we_q    <= pick ? we1 : we0;
        addr_q  <= pick ? addr1 : addr0;
        wdata_q <= pick ? wdata1 : wdata0;
      end
      if (state == DAT_PW && cnt == PW_L && !we_q)
        rdata <= eth_data;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 4'd1;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (any_req) state_n = IDX_SU;
      end
      IDX_SU: if (cnt == SU_L) begin
        state_n = IDX_PW;
        cnt_n   = '0;
      end
      IDX_PW: if (cnt == PW_L) begin
        state_n = IDX_HD;
        cnt_n   = '0;
      end
      IDX_HD: if (cnt == HD_L) begin
        state_n = DAT_SU;
        cnt_n   = '0;
      end
      DAT_SU: if (cnt == SU_L) begin
        state_n = DAT_PW;
        cnt_n   = '0;
      end
      DAT_PW: if (cnt == PW_L) begin
        state_n = DAT_HD;
        cnt_n   = '0;
      end
      DAT_HD: if (cnt == HD_L) begin
        state_n = DONE;
        cnt_n   = '0;
      end
      DONE: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign idx = (state == IDX_SU) | (state == IDX_PW) | (state == IDX_HD);
  assign dat = (state == DAT_SU) | (state == DAT_PW) | (state == DAT_HD);

  assign busy  = (state != IDLE);
  assign gnt0  = busy & ~own;
  assign gnt1  = busy & own;
  assign done0 = (state == DONE) & ~own;
  assign done1 = (state == DONE) & own;

  assign eth_cs  = ~(idx | dat);
  assign eth_cmd = ~idx;
  assign eth_iow = ~((state == IDX_PW) | ((state == DAT_PW) & we_q));
  assign eth_ior = ~((state == DAT_PW) & ~we_q);

  // reads release the bus for the whole data phase
  assign drive = idx | (dat & we_q);
  assign dout  = idx ? {8'h00, addr_q} : wdata_q;
  assign eth_data = drive ? dout : 16'hzzzz;

endmodule

// File: tb/tb_dm9000_bus_arbiter.sv
// Bench for dm9000_bus_arbiter: transaction-level model plus directed cases.
// Checks default timing unit and a T_SU=2/T_PW=3 unit.
`timescale 1ns/1ps
module tb_dm9000_bus_arbiter;

  localparam int SU = 1, PW = 2, HD = 1;
  localparam int H = SU + PW + HD;
  localparam int L = 2 * H;
  localparam logic [15:0] FLOAT = 16'hFFFF;

  logic        clk50M = 0;
  logic        rst_key = 1;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [7:0]  addr0 = 0, addr1 = 0;
  logic [15:0] wdata0 = 0, wdata1 = 0;
  logic [15:0] dev_rdata = 16'h0000;
  logic        gnt0, gnt1, done0, done1, busy;
  logic        eth_cs, eth_cmd, eth_ior, eth_iow;
  logic [15:0] rdata;
  wire  [15:0] eth_data;

  logic        p_req = 0, zb = 0, p_we = 1;
  logic [7:0]  p_addr = 8'h28, z8 = 0;
  logic [15:0] p_wd = 16'h1234, z16 = 0;
  logic        p_gnt0, p_gnt1, p_done0, p_done1, p_busy;
  logic        p_cs, p_cmd, p_ior, p_iow;
  logic [15:0] p_rdata;
  wire  [15:0] p_data;

  int checks = 0, failures = 0;
  logic started = 0;

  always #10 clk50M = ~clk50M;

  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup pu (eth_data[i]);
  end
  assign eth_data = eth_ior ? 16'hzzzz : dev_rdata;

  dm9000_bus_arbiter dut (
    .clk50M(clk50M), .rst_key(rst_key),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .busy(busy), .eth_data(eth_data),
    .eth_cs(eth_cs), .eth_cmd(eth_cmd),
    .eth_ior(eth_ior), .eth_iow(eth_iow)
  );

  dm9000_bus_arbiter #(.T_SU(2), .T_PW(3), .T_HD(1)) u1 (
    .clk50M(clk50M), .rst_key(rst_key),
    .req0(p_req), .req1(zb), .we0(p_we), .we1(zb),
    .addr0(p_addr), .addr1(z8),
    .wdata0(p_wd), .wdata1(z16),
    .gnt0(p_gnt0), .gnt1(p_gnt1), .done0(p_done0), .done1(p_done1),
    .rdata(p_rdata), .busy(p_busy), .eth_data(p_data),
    .eth_cs(p_cs), .eth_cmd(p_cmd),
    .eth_ior(p_ior), .eth_iow(p_iow)
  );

  // transaction model: m_t counts cycles since grant, L is the DONE cycle
  bit          m_act = 0, m_own = 0, m_we = 0, m_last = 1;
  int          m_t = 0;
  logic [7:0]  m_addr = 0;
  logic [15:0] m_wdata = 0, m_rdata = 0;

  always @(posedge clk50M or negedge rst_key) begin
    if (!rst_key) begin
      m_act = 0; m_t = 0; m_rdata = 0; m_last = 1; m_own = 0;
    end else if (!m_act) begin
      if (req0 || req1) begin
`ifdef ETH_ARB_RR_EN
        m_own = (req0 && req1) ? !m_last : req1;
`else
        m_own = !req0;
`endif
        m_last  = m_own;
        m_act   = 1;
        m_t     = 0;
        m_we    = m_own ? we1 : we0;
        m_addr  = m_own ? addr1 : addr0;
        m_wdata = m_own ? wdata1 : wdata0;
      end
    end else begin
      if (!m_we && m_t == H + SU + PW - 1) m_rdata = dev_rdata;
      if (m_t == L) m_act = 0;
      else m_t++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk50M) if (started) begin
    bit idx, inpw, xfer;
    int q;
    logic e_cs, e_cmd, e_ior, e_iow;
    logic [15:0] e_bus;
    idx  = m_t < H;
    q    = idx ? m_t : m_t - H;
    inpw = q >= SU && q < SU + PW;
    xfer = m_act && m_t < L;
    e_cs  = !xfer;
    e_cmd = !(xfer && idx);
    e_iow = !(xfer && inpw && (idx || m_we));
    e_ior = !(xfer && inpw && !idx && !m_we);
    if (xfer && (idx || m_we)) e_bus = idx ? {8'h00, m_addr} : m_wdata;
    else e_bus = !e_ior ? dev_rdata : FLOAT;
    chk("ctrl", {gnt0, gnt1, done0, done1, busy,
                 eth_cs, eth_cmd, eth_ior, eth_iow},
        {23'd0, m_act && !m_own, m_act && m_own,
         m_act && !m_own && m_t == L, m_act && m_own && m_t == L,
         m_act, e_cs, e_cmd, e_ior, e_iow});
    chk("bus", {16'd0, eth_data}, {16'd0, e_bus});
    chk("rdata", {16'd0, rdata}, {16'd0, m_rdata});
  end

  logic [15:0] tgt_idx = 0, tgt_dat = 0;
  int idx_hits = 0, dat_hits = 0, n_done0 = 0, float_bad = 0;
  int p_iow_low = 0, p_dat_low = 0;
  logic prev_g = 0;
  int gq[$];

  always @(negedge clk50M) begin
    if (!eth_cs && !eth_cmd && !eth_iow && eth_data == tgt_idx)
      idx_hits++;
    if (!eth_cs && eth_cmd && !eth_iow && eth_data == tgt_dat)
      dat_hits++;
    if (done0) n_done0++;
    if (!eth_cs && eth_cmd && eth_ior && eth_iow && eth_data !== FLOAT)
      float_bad++;
    if (!p_iow) p_iow_low++;
    if (p_cmd && !p_iow) p_dat_low++;
    if ((gnt0 || gnt1) && !prev_g) gq.push_back(int'(gnt1));
    prev_g = gnt0 || gnt1;
  end

  function automatic logic sig(input int k);
    case (k)
      0: sig = gnt0;
      1: sig = gnt1;
      2: sig = done0;
      3: sig = done1;
      4: sig = !eth_iow && !eth_cmd;
      5: sig = p_gnt0;
      6: sig = p_done0;
      7: sig = !busy;
      default: sig = 0;
    endcase
  endfunction

  task automatic wait_for(input string nm, input int k,
                          input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk50M);
      n++;
    end while (!sig(k) && n < budget);
    chk(nm, {31'd0, sig(k)}, 32'd1);
  endtask

  task automatic go_pos;
    @(posedge clk50M);
    #1;
  endtask

  task automatic clr;
    idx_hits = 0; dat_hits = 0; n_done0 = 0;
    float_bad = 0; p_iow_low = 0; p_dat_low = 0;
  endtask

  initial begin
    int n;
    #3 rst_key = 0;
    #2 started = 1;
    @(negedge clk50M);
    chk("rst_gnt0", {31'd0, gnt0}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_rdata", {16'd0, rdata}, 0);
    chk("rst_cs", {31'd0, eth_cs}, 1);
    chk("rst_bus", {16'd0, eth_data}, {16'd0, FLOAT});
    go_pos;
    rst_key = 1;

    // write
    tgt_idx = 16'h0028; tgt_dat = 16'h1234; clr();
    go_pos;
    req0 = 1; we0 = 1; addr0 = 8'h28; wdata0 = 16'h1234;
    wait_for("wr_gnt0", 0, 10, n);
    req0 = 0;
    wait_for("wr_done0", 2, 20, n);
    chk("wr_g2d", n, 8);
    repeat (3) @(negedge clk50M);
    chk("wr_idx_cyc", idx_hits, 2);
    chk("wr_dat_cyc", dat_hits, 2);
    chk("wr_done_cnt", n_done0, 1);

    // read
    tgt_idx = 16'h0029; tgt_dat = 16'h0000; dev_rdata = 16'h0A46; clr();
    go_pos;
    req1 = 1; we1 = 0; addr1 = 8'h29;
    wait_for("rd_gnt1", 1, 10, n);
    req1 = 0;
    wait_for("rd_done1", 3, 20, n);
    chk("rd_g2d", n, 8);
    chk("rd_rdata", {16'd0, rdata}, 32'h0A46);
    repeat (3) @(negedge clk50M);
    chk("rd_idx_cyc", idx_hits, 2);
    chk("rd_float", float_bad, 0);

    // tie
    gq.delete();
    go_pos;
    req0 = 1; req1 = 1; we0 = 1; we1 = 1;
    wdata0 = 16'h0A0A; wdata1 = 16'hB0B0; addr1 = 8'h31;
    n = 0;
    while (gq.size() < 4 && n < 80) begin
      @(negedge clk50M);
      n++;
    end
    req0 = 0; req1 = 0;
    chk("tie_count", gq.size() >= 4, 1);
    wait_for("tie_idle", 7, 20, n);
    if (gq.size() >= 4) begin
`ifdef ETH_ARB_RR_EN
      chk("tie_seq", {gq[0], gq[1], gq[2], gq[3]}, {32'd0, 32'd1, 32'd0, 32'd1});
`else
      chk("tie_seq", {gq[0], gq[1], gq[2], gq[3]}, 128'd0);
`endif
    end

    // req drop with changed address
    tgt_idx = 16'h0028; tgt_dat = 16'hBEEF; clr();
    go_pos;
    req0 = 1; we0 = 1; addr0 = 8'h28; wdata0 = 16'hBEEF;
    wait_for("drop_gnt0", 0, 10, n);
    req0 = 0; addr0 = 8'h55; wdata0 = 16'h0000;
    wait_for("drop_done0", 2, 20, n);
    chk("drop_g2d", n, 8);
    repeat (12) @(negedge clk50M);
    chk("drop_done_cnt", n_done0, 1);
    chk("drop_idx_cyc", idx_hits, 2);
    chk("drop_dat_cyc", dat_hits, 2);

    // reset during IDX_PW
    clr();
    go_pos;
    req0 = 1; we0 = 1; addr0 = 8'h28; wdata0 = 16'h1111;
    wait_for("rst_idxpw", 4, 10, n);
    req0 = 0;
    #2 rst_key = 0;
    #1;
    chk("rmid_iow", {31'd0, eth_iow}, 1);
    chk("rmid_cs", {31'd0, eth_cs}, 1);
    chk("rmid_bus", {16'd0, eth_data}, {16'd0, FLOAT});
    chk("rmid_gnt0", {31'd0, gnt0}, 0);
    repeat (4) @(negedge clk50M);
    chk("rmid_nodone", n_done0, 0);
    go_pos;
    rst_key = 1;
    go_pos;

    // stretched timing unit
    clr();
    go_pos;
    p_req = 1;
    wait_for("p_gnt0", 5, 10, n);
    p_req = 0;
    wait_for("p_done0", 6, 30, n);
    chk("p_g2d", n, 12);
    repeat (3) @(negedge clk50M);
    chk("p_dat_low", p_dat_low, 3);
    chk("p_iow_low", p_iow_low, 6);

    repeat (2) @(negedge clk50M);
    started = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
